// File: rtl/cmd_frame_tx_pkg.sv
// ---------------------------------------------------------------------------
// cmd_frame_tx_pkg
// Shared UART framing constants, the frame transmitter state type and the
// checksum helper used by cmd_frame_tx and anything that builds or parses
// command frames.
//   UART_FIFO_COUNTER_W : width of the UART TX FIFO fill-level counter
//   UART_FIFO_DEPTH     : FIFO depth; a fill level at or above this is full
//   FRAME_*             : fixed header/tail bytes of a command frame
//   SWITCH_BOARD_ID     : default board identifier
//   CMD_*               : recognised command codes
// ---------------------------------------------------------------------------
package cmd_frame_tx_pkg;

  localparam int UART_FIFO_COUNTER_W = 5;
  localparam logic [UART_FIFO_COUNTER_W-1:0] UART_FIFO_DEPTH = 5'd16;

  localparam logic [7:0] FRAME_HEAD0     = 8'hEB;
  localparam logic [7:0] FRAME_HEAD1     = 8'h90;
  localparam logic [7:0] FRAME_TAIL0     = 8'h09;
  localparam logic [7:0] FRAME_TAIL1     = 8'hD7;
  localparam logic [7:0] SWITCH_BOARD_ID = 8'hAB;

  localparam logic [7:0] CMD_0A = 8'h0A;
  localparam logic [7:0] CMD_0B = 8'h0B;
  localparam logic [7:0] CMD_A0 = 8'hA0;
  localparam logic [7:0] CMD_B0 = 8'hB0;
  localparam logic [7:0] CMD_AB = 8'hAB;
  localparam logic [7:0] CMD_BA = 8'hBA;
  localparam logic [7:0] CMD_AA = 8'hAA;
  localparam logic [7:0] CMD_55 = 8'h55;
  localparam logic [7:0] CMD_BB = 8'hBB;
  localparam logic [7:0] CMD_44 = 8'h44;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    PUSH = 3'd2,
    GAP1 = 3'd3,
    GAP2 = 3'd4,
    DONE = 3'd5
  } frame_state_t;

  // Checksum chosen so that arg + board + code + csum wraps to 8'h00.
  function automatic logic [7:0] calcCsum(input logic [7:0] arg,
                                          input logic [7:0] board,
                                          input logic [7:0] code);
    return 8'h00 - (arg + board + code);
  endfunction

endpackage

// File: rtl/cmd_frame_tx_if.sv
// ---------------------------------------------------------------------------
// cmd_frame_tx_if
// Bundles the command handshake, the UART TX FIFO write side and the status
// pulses of cmd_frame_tx.
//   cmd_valid/cmd_code/cmd_arg/cmd_ready : command request handshake
//   tf_counter                           : UART TX FIFO fill level
//   tf_push/tdr                          : FIFO write strobe and data byte
//   busy/frame_done/error                : frame progress and result
// Modports: slave = the frame transmitter, master = the command source.
// ---------------------------------------------------------------------------
interface cmd_frame_tx_if;
  import cmd_frame_tx_pkg::*;

  logic                           cmd_valid;
  logic [7:0]                     cmd_code;
  logic [7:0]                     cmd_arg;
  logic                           cmd_ready;
  logic [UART_FIFO_COUNTER_W-1:0] tf_counter;
  logic                           tf_push;
  logic [7:0]                     tdr;
  logic                           busy;
  logic                           frame_done;
  logic                           error;

  modport master (
    output cmd_valid, cmd_code, cmd_arg, tf_counter,
    input  cmd_ready, tf_push, tdr, busy, frame_done, error
  );

  modport slave (
    input  cmd_valid, cmd_code, cmd_arg, tf_counter,
    output cmd_ready, tf_push, tdr, busy, frame_done, error
  );

endinterface

// File: rtl/cmd_frame_tx.sv
// ---------------------------------------------------------------------------
// cmd_frame_tx
// Turns one accepted command into an 8-byte frame
//   EB 90 arg BOARD_ID code csum 09 D7
// written byte by byte into a UART TX FIFO, never faster than one push every
// three cycles, waiting while the FIFO is full and aborting the frame when
// it stays full for STALL_LIMIT consecutive cycles.
// Parameters: BOARD_ID (frame byte 3), STALL_LIMIT (full cycles before abort)
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : cmd_frame_tx_if.slave (handshake, FIFO write side, status)
// ---------------------------------------------------------------------------
module cmd_frame_tx
  import cmd_frame_tx_pkg::*;
#(
  parameter logic [7:0]  BOARD_ID    = SWITCH_BOARD_ID,
  parameter logic [31:0] STALL_LIMIT = 32'd50000
) (
  input  logic           clk,
  input  logic           rst,
  cmd_frame_tx_if.slave  bus
);

  frame_state_t r_state;
  frame_state_t w_nextState;

  logic [7:0]  r_code;
  logic [7:0]  r_arg;
  logic [7:0]  r_csum;
  logic [2:0]  r_byteIdx;
  logic [31:0] r_stall;
  logic [7:0]  r_tdr;

  logic        w_accept;
  logic        w_full;
  logic        w_push;
  logic        w_error;
  logic [31:0] w_stallNext;
  logic        w_stallHit;
  logic [7:0]  w_frameByte;

  assign w_accept    = (r_state == IDLE) && bus.cmd_valid;
  assign w_full      = (bus.tf_counter >= UART_FIFO_DEPTH);
  assign w_stallNext = r_stall + 32'd1;
  assign w_stallHit  = w_full && (w_stallNext >= STALL_LIMIT);

  always_comb begin
    w_frameByte = FRAME_HEAD0;
    case (r_byteIdx)
      3'd0:    w_frameByte = FRAME_HEAD0;
      3'd1:    w_frameByte = FRAME_HEAD1;
      3'd2:    w_frameByte = r_arg;
      3'd3:    w_frameByte = BOARD_ID;
      3'd4:    w_frameByte = r_code;
      3'd5:    w_frameByte = r_csum;
      3'd6:    w_frameByte = FRAME_TAIL0;
      default: w_frameByte = FRAME_TAIL1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // The two gap states space pushes three cycles apart so the FIFO fill level
  // reflects the previous push before the next full check; byte_idx wrapping
  // back to zero marks that byte 7 has gone out.
  always_comb begin
    w_nextState = r_state;
    w_push      = 1'b0;
    w_error     = 1'b0;
    case (r_state)
      IDLE: if (bus.cmd_valid) w_nextState = LOAD;
      LOAD: w_nextState = PUSH;
      PUSH: begin
        if (!w_full) begin
          w_push      = 1'b1;
          w_nextState = GAP1;
        end else if (w_stallHit) begin
          w_error     = 1'b1;
          w_nextState = IDLE;
        end
      end
      GAP1: w_nextState = GAP2;
      GAP2: w_nextState = (r_byteIdx == 3'd0) ? DONE : PUSH;
      DONE: w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_code    <= 8'h00;
      r_arg     <= 8'h00;
      r_csum    <= 8'h00;
      r_byteIdx <= 3'd0;
      r_stall   <= 32'd0;
      r_tdr     <= 8'h00;
    end else if (w_accept) begin
      r_code    <= bus.cmd_code;
      r_arg     <= bus.cmd_arg;
      r_csum    <= calcCsum(bus.cmd_arg, BOARD_ID, bus.cmd_code);
      r_byteIdx <= 3'd0;
      r_stall   <= 32'd0;
    end else if (r_state == PUSH) begin
      if (w_push) begin
        r_tdr     <= w_frameByte;
        r_byteIdx <= r_byteIdx + 3'd1;
        r_stall   <= 32'd0;
      end else begin
        r_stall   <= w_stallNext;
      end
    end
  end

  // tdr shows the byte being pushed in the push cycle itself and keeps the
  // last pushed byte afterwards.
  assign bus.tdr        = w_push ? w_frameByte : r_tdr;
  assign bus.tf_push    = w_push;
  assign bus.cmd_ready  = (r_state == IDLE);
  assign bus.busy       = (r_state != IDLE);
  assign bus.frame_done = (r_state == DONE);
  assign bus.error      = w_error;

endmodule

// File: doc/cmd_frame_tx.md
CMD_FRAME_TX -- requirements
Module: cmd_frame_tx

Interface
REQ-001 The block SHALL have parameter BOARD_ID, default 8'hAB: the board ID placed in frame byte 3.
REQ-002 The block SHALL have parameter STALL_LIMIT, default 32'd50000: the number of consecutive full-FIFO cycles that aborts a frame.
REQ-003 The block SHALL have port clk, input, 1 bit: the system clock; every register updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port cmd_valid, input, 1 bit: a command request is present.
REQ-006 The block SHALL have port cmd_code, input, 8 bits: the command byte, frame byte 4 (0A, 0B, A0, B0, AB, BA, AA, 55, BB, 44).
REQ-007 The block SHALL have port cmd_arg, input, 8 bits: the argument byte, frame byte 2.
REQ-008 The block SHALL have port tf_counter, input, `UART_FIFO_COUNTER_W bits: the UART TX FIFO fill level.
REQ-009 The block SHALL have port cmd_ready, output, 1 bit: high only in IDLE.
REQ-010 The block SHALL have port tf_push, output, 1 bit: a one-cycle write strobe to the UART TX FIFO.
REQ-011 The block SHALL have port tdr, output, 8 bits: the byte presented with tf_push.
REQ-012 The block SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-013 The block SHALL have port frame_done, output, 1 bit: a one-cycle pulse after byte 7 is pushed.
REQ-014 The block SHALL have port error, output, 1 bit: a one-cycle pulse when a frame is aborted on stall.

Function
REQ-015 The frame SHALL be bytes 0-7 = EB, 90, arg, BOARD_ID, code, csum, 09, D7, in that order.
REQ-016 csum SHALL be (0 - (arg + BOARD_ID + code)) mod 256, so that bytes 2..5 sum to 8'h00 (8-bit wrap).
REQ-017 The states SHALL be IDLE, LOAD, PUSH, GAP1, GAP2, DONE.
REQ-018 In IDLE, cmd_valid & cmd_ready SHALL capture code and arg, compute csum, clear byte_idx and the stall counter, and go to LOAD.
REQ-019 LOAD SHALL last exactly one cycle and then go to PUSH.
REQ-020 In PUSH, when tf_counter < `UART_FIFO_DEPTH: assert tf_push for one cycle with tdr = frame[byte_idx], increment byte_idx, clear the stall counter, and go to GAP1.
REQ-021 In PUSH, when tf_counter >= `UART_FIFO_DEPTH: hold, do not push, and increment the stall counter.
REQ-022 GAP1 -> GAP2 -> PUSH SHALL give pushes a fixed three-cycle minimum spacing, so the FIFO counter settles before the next full check.
REQ-023 After the byte-7 push (byte_idx wraps from 7 to 0), GAP2 SHALL go to DONE instead of PUSH.
REQ-024 DONE SHALL pulse frame_done for one cycle and return to IDLE.
REQ-025 Timing: handshake at cycle 0 gives the first tf_push at cycle 2 and the last at cycle 23 when the FIFO never fills; frame_done is at cycle 26.
REQ-026 When the stall counter reaches STALL_LIMIT in PUSH, the block SHALL pulse error, push nothing further, and return to IDLE; partial bytes already in the FIFO are not retracted.
REQ-027 cmd_valid while busy SHALL be ignored, with no queuing.
REQ-028 Simultaneous cmd_valid and an error or frame_done cycle SHALL NOT be accepted; it is accepted the following cycle in IDLE.
REQ-029 tdr SHALL hold the last pushed byte between pushes, and SHALL be 8'h00 after reset.
REQ-030 tf_push SHALL never be high for two consecutive cycles.

Reset
REQ-031 On rst=1, the block SHALL immediately, without waiting for a clock edge, force state=IDLE, tf_push=0, tdr=8'h00, busy=0, cmd_ready=1, frame_done=0, error=0, byte_idx=0, stall counter=0.
REQ-032 Reset mid-frame SHALL abandon the frame with no further pushes; the first accepted command after release SHALL send a complete fresh frame.

Structure
REQ-033 The constants FRAME_HEAD0 (EB), FRAME_HEAD1 (90), FRAME_TAIL0 (09), FRAME_TAIL1 (D7), SWITCH_BOARD_ID (AB), the command codes, and UART_FIFO_DEPTH (16) SHALL reside in the shared uart_defines.v include.
REQ-034 The block SHALL be implemented as a single module with no sub-module; the checksum and byte mux are inline.

Verification
REQ-035 Bench scenario: code=0A, arg=00, tf_counter=0 -> pushes EB 90 00 AB 0A 4B 09 D7 at cycles 2, 5, ..., 23; frame_done at cycle 26.
REQ-036 Bench scenario: code=B0, arg=12 -> csum=93; bytes 2..5 sum to 8'h00; frame EB 90 12 AB B0 93 09 D7.
REQ-037 Bench scenario: tf_counter=16 held for 10 cycles while PUSH holds byte 3 -> no tf_push during the hold; byte 3 (AB) is pushed on the first cycle tf_counter=15; the frame then completes.
REQ-038 Bench scenario: STALL_LIMIT=8 and tf_counter=16 held -> error pulses once after 8 stall cycles, no frame_done, and cmd_ready=1 the next cycle.
REQ-039 Bench scenario: rst asserted between bytes 4 and 5 -> tf_push=0 immediately; a new command after release sends all 8 bytes starting with EB.
REQ-040 Bench scenario: cmd_valid held high for 40 cycles -> exactly one frame is sent per IDLE acceptance, and no tf_push pulses are adjacent.
